// File: rtl/pwr_seq_gen_pkg.sv
// Shared types and constants for the power-up sequencer and its users.
// Stage indices name the enables in the order they are released.
package pwr_seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    RUN  = 2'd2,
    DOWN = 2'd3
  } seq_state_t;

  localparam int PWR_STAGE_CAM  = 0;
  localparam int PWR_STAGE_PIPE = 1;
  localparam int PWR_STAGE_I2C  = 2;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwr_seq_gen_sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous level signals.
// Reset value is zero, so a synchronised "ready" level starts deasserted.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwr_seq_gen.sv
// Ordered power-up/down sequencer gated by PLL lock, plus a free-running
// strobe divider and an LED heartbeat divider.
//
// state | meaning
// IDLE  | waiting for lock, all stages off
// UP    | releasing stages lowest first, STAGE_DLY apart
// RUN   | all stages on, seq_done high
// DOWN  | clearing stages highest first before re-entering UP
module pwr_seq_gen
  import pwr_seq_gen_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_DLY  = 100_000,
  parameter int STROBE_DIV = 250,
  parameter int HB_DIV     = 50_000_000
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  pll_locked,
  input  logic                  sw_restart,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  seq_done,
  output logic                  strobe,
  output logic                  heartbeat,
  output logic [1:0]            seq_state
);

  localparam int DLY_W = cnt_w(STAGE_DLY);
  localparam int IDX_W = cnt_w(NUM_STAGES);
  localparam int STB_W = cnt_w(STROBE_DIV);
  localparam int HB_W  = cnt_w(HB_DIV);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_DIV - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_DIV - 1);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .d        (pll_locked),
    .q        (lock_s)
  );

  seq_state_t             state, state_nxt;
  logic [DLY_W-1:0]       dly_cnt, dly_cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [NUM_STAGES-1:0]  stage_en_nxt;
  logic                   seq_done_nxt;
  logic                   dly_tick;
  logic [NUM_STAGES-1:0]  idx_mask;

  assign dly_tick = (dly_cnt == DLY_LAST);
  assign idx_mask = NUM_STAGES'(1) << idx;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      idx      <= '0;
      stage_en <= '0;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly_cnt  <= dly_cnt_nxt;
      idx      <= idx_nxt;
      stage_en <= stage_en_nxt;
      seq_done <= seq_done_nxt;
    end
  end

  // Lock loss overrides everything, including a restart in the same cycle.
  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    idx_nxt     = idx;
    if (!lock_s) begin
      state_nxt   = IDLE;
      dly_cnt_nxt = '0;
      idx_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = UP;
          dly_cnt_nxt = '0;
          idx_nxt     = '0;
        end
        UP: begin
          if (dly_tick) begin
            dly_cnt_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = RUN;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            dly_cnt_nxt = dly_cnt + 1'b1;
          end
        end
        RUN: begin
          if (sw_restart) begin
            state_nxt   = DOWN;
            dly_cnt_nxt = '0;
            idx_nxt     = IDX_LAST;
          end
        end
        DOWN: begin
          if (dly_tick) begin
            dly_cnt_nxt = '0;
            if (idx == '0) begin
              state_nxt = UP;
            end else begin
              idx_nxt = idx - 1'b1;
            end
          end else begin
            dly_cnt_nxt = dly_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    stage_en_nxt = stage_en;
    seq_done_nxt = (state_nxt == RUN);
    if (!lock_s) begin
      stage_en_nxt = '0;
    end else begin
      case (state)
        IDLE:    stage_en_nxt = '0;
        UP:      if (dly_tick) stage_en_nxt = stage_en | idx_mask;
        DOWN:    if (dly_tick) stage_en_nxt = stage_en & ~idx_mask;
        default: stage_en_nxt = stage_en;
      endcase
    end
  end

  assign seq_state = state;

  logic [STB_W-1:0] stb_cnt;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      stb_cnt <= '0;
    end else if (stb_cnt == STB_LAST) begin
      stb_cnt <= '0;
    end else begin
      stb_cnt <= stb_cnt + 1'b1;
    end
  end

  assign strobe = (stb_cnt == STB_LAST);

  // Toggle on the edge the counter arrives at its last value, so the
  // first rise is visible HB_DIV-1 cycles after reset release.
  logic [HB_W-1:0] hb_cnt, hb_cnt_nxt;

  assign hb_cnt_nxt = (hb_cnt == HB_LAST) ? '0 : hb_cnt + 1'b1;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt_nxt;
      if (hb_cnt_nxt == HB_LAST) heartbeat <= ~heartbeat;
    end
  end

endmodule

// File: tb/tb_pwr_seq_gen.sv
// Scoreboard bench for pwr_seq_gen: expectations are queued with the cycle
// they fall due and compared by a negedge monitor.
module tb_pwr_seq_gen;
  import pwr_seq_gen_pkg::*;

  localparam int NS = 3, SD = 10, SDIV = 4, HD = 8;
  localparam int F_STAGE = 0, F_DONE = 1, F_STATE = 2, F_STROBE = 3, F_HB = 4;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          sw_restart = 1'b0;
  logic [NS-1:0] stage_en;
  logic          seq_done, strobe, heartbeat;
  logic [1:0]    seq_state;

  pwr_seq_gen #(
    .NUM_STAGES (NS),
    .STAGE_DLY  (SD),
    .STROBE_DIV (SDIV),
    .HB_DIV     (HD)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .pll_locked (pll_locked),
    .sw_restart (sw_restart),
    .stage_en   (stage_en),
    .seq_done   (seq_done),
    .strobe     (strobe),
    .heartbeat  (heartbeat),
    .seq_state  (seq_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] observe(input int f);
    case (f)
      F_STAGE:  return 32'(stage_en);
      F_DONE:   return 32'(seq_done);
      F_STATE:  return 32'(seq_state);
      F_STROBE: return 32'(strobe);
      default:  return 32'(heartbeat);
    endcase
  endfunction

  task automatic expect_at(input int c, input int f, input logic [31:0] v, input string tag);
    exp_t e;
    int   i;
    e.cyc = c; e.fld = f; e.val = v; e.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("%s@%0d", e.tag, e.cyc), observe(e.fld), e.val);
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  localparam logic [31:0] S1 = 32'(1) << PWR_STAGE_CAM;
  localparam logic [31:0] S2 = S1 | (32'(1) << PWR_STAGE_PIPE);
  localparam logic [31:0] S3 = S2 | (32'(1) << PWR_STAGE_I2C);

  // Full power-up from UP entry at cycle u.
  task automatic push_up(input int u, input string p);
    expect_at(u + SD - 1,   F_STAGE, 0,  {p, "_s0_pre"});
    expect_at(u + SD,       F_STAGE, S1, {p, "_s0"});
    expect_at(u + 2*SD - 1, F_STAGE, S1, {p, "_s1_pre"});
    expect_at(u + 2*SD,     F_STAGE, S2, {p, "_s1"});
    expect_at(u + 3*SD - 1, F_STAGE, S2, {p, "_s2_pre"});
    expect_at(u + 3*SD - 1, F_DONE,  0,  {p, "_done_pre"});
    expect_at(u + 3*SD,     F_STAGE, S3, {p, "_s2"});
    expect_at(u + 3*SD,     F_DONE,  1,  {p, "_done"});
    expect_at(u + 3*SD,     F_STATE, 32'(RUN), {p, "_run"});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int base, u, r, l0, l1, d0, d1, u2;
    repeat (3) @(negedge clk);
    chk("rst_stage", 32'(stage_en), 0);
    chk("rst_done",  32'(seq_done), 0);
    chk("rst_strobe", 32'(strobe), 0);
    chk("rst_hb",    32'(heartbeat), 0);
    chk("rst_state", 32'(seq_state), 32'(IDLE));

    // Power-up with lock present at release; dividers checked alongside.
    areset_n = 1'b1;
    pll_locked = 1'b1;
    base = cyc;
    for (int k = 1; k <= 12; k++)
      expect_at(base + k, F_STROBE, 32'((k % SDIV) == SDIV - 1), "strobe");
    for (int k = 1; k <= 16; k++)
      expect_at(base + k, F_HB, 32'(((k + 1) / HD) % 2), "hb");
    expect_at(base + 2, F_STATE, 32'(IDLE), "lock_sync_idle");
    expect_at(base + 3, F_STATE, 32'(UP), "lock_sync_up");
    u = base + 3;
    push_up(u, "pwrup");
    wait_until(u + 3*SD + 2);

    // Software restart: ordered power-down then power-up.
    sw_restart = 1'b1;
    r = cyc + 1;
    @(negedge clk);
    sw_restart = 1'b0;
    expect_at(r,        F_DONE,  0, "rs_done_drop");
    expect_at(r,        F_STATE, 32'(DOWN), "rs_down");
    expect_at(r + SD - 1, F_STAGE, S3, "rs_d2_pre");
    expect_at(r + SD,     F_STAGE, S2, "rs_d2");
    expect_at(r + 2*SD,   F_STAGE, S1, "rs_d1");
    expect_at(r + 3*SD,   F_STAGE, 0,  "rs_d0");
    expect_at(r + 3*SD,   F_STATE, 32'(UP), "rs_up");
    push_up(r + 3*SD, "rs");
    wait_until(r + 6*SD + 2);

    // Lock loss in RUN with a coincident restart: lock loss wins.
    l0 = cyc;
    pll_locked = 1'b0;
    expect_at(l0 + 2, F_STAGE, S3, "ll_hold");
    expect_at(l0 + 2, F_STATE, 32'(RUN), "ll_hold_state");
    expect_at(l0 + 3, F_STAGE, 0, "ll_stage");
    expect_at(l0 + 3, F_DONE,  0, "ll_done");
    expect_at(l0 + 3, F_STATE, 32'(IDLE), "ll_idle");
    expect_at(l0 + 4, F_STATE, 32'(IDLE), "ll_no_down");
    wait_until(l0 + 2);
    sw_restart = 1'b1;
    @(negedge clk);
    sw_restart = 1'b0;
    wait_until(l0 + 5);

    // Relock, then drop lock mid-UP with only stage 0 on.
    l1 = cyc;
    pll_locked = 1'b1;
    expect_at(l1 + 3, F_STATE, 32'(UP), "relock_up");
    expect_at(l1 + 3 + SD, F_STAGE, S1, "relock_s0");
    wait_until(l1 + 4 + SD);
    d0 = cyc;
    pll_locked = 1'b0;
    expect_at(d0 + 2, F_STAGE, S1, "mid_hold");
    expect_at(d0 + 2, F_STATE, 32'(UP), "mid_hold_state");
    expect_at(d0 + 3, F_STAGE, 0, "mid_stage");
    expect_at(d0 + 3, F_STATE, 32'(IDLE), "mid_idle");
    wait_until(d0 + 4);

    // Re-raise: full delays again; restart during UP is ignored.
    d1 = cyc;
    pll_locked = 1'b1;
    u2 = d1 + 3;
    expect_at(u2 - 1, F_STATE, 32'(IDLE), "rr_idle");
    expect_at(u2,     F_STATE, 32'(UP), "rr_up");
    push_up(u2, "rr");
    wait_until(u2 + SD + 2);
    sw_restart = 1'b1;
    expect_at(u2 + SD + 3, F_STATE, 32'(UP), "ign_state");
    expect_at(u2 + SD + 3, F_STAGE, S1, "ign_stage");
    @(negedge clk);
    sw_restart = 1'b0;
    wait_until(u2 + 3*SD + 3);

    // Asynchronous reset in RUN, between clock edges.
    #2;
    areset_n = 1'b0;
    #1;
    chk("arst_stage", 32'(stage_en), 0);
    chk("arst_done",  32'(seq_done), 0);
    chk("arst_strobe", 32'(strobe), 0);
    chk("arst_hb",    32'(heartbeat), 0);
    chk("arst_state", 32'(seq_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    base = cyc;
    for (int k = 1; k <= 8; k++)
      expect_at(base + k, F_STROBE, 32'((k % SDIV) == SDIV - 1), "arst_strobe_seq");
    expect_at(base + 3, F_STATE, 32'(UP), "arst_up");
    expect_at(base + 3 + SD, F_STAGE, S1, "arst_s0");
    wait_until(base + SD + 6);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
